param_pipelined_core: RTL and testbench

PARAM_PIPELINED_CORE -- requirements
Module: param_pipelined_core

---
 rtl/param_pipelined_core.sv | 166 ++++++++++++++++
 tb/tb_param_pipelined_core.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_pipelined_core.sv
// rtl/param_pipelined_core.sv - four-stage move/shift core; PIPE_FWD_EN selects EX forwarding over ID stall
module param_pipelined_core #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Run,
   output logic [PC_W-1:0]   Imem_Addr,
   input  logic [7:0]        Imem_Data,
   output logic              Wb_Valid,
   output logic [2:0]        Wb_Reg,
   output logic [DATA_W-1:0] Wb_Data
);

   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_SRL = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   // fetch state
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   pc_next;
   logic [PC_W-1:0]   jmp_offset;
   logic [1:0]        if_op;

   // IF/ID
   logic              if_id_valid;
   logic [7:0]        if_id_instr;

   // decode view of IF/ID
   logic [1:0]        id_op;
   logic [2:0]        id_rd;
   logic [2:0]        id_rs;
   logic [2:0]        id_src;
   logic [DATA_W-1:0] id_opnd;

   // ID/EX
   logic              id_ex_valid;
   logic [1:0]        id_ex_op;
   logic [2:0]        id_ex_rd;
   logic [2:0]        id_ex_imm;
   logic [DATA_W-1:0] id_ex_opnd;
`ifdef PIPE_FWD_EN
   logic [2:0]        id_ex_src;
`endif

   // execute
   logic [DATA_W-1:0] ex_opnd;
   logic [DATA_W-1:0] ex_result;

   // EX/WB
   logic              ex_wb_valid;
   logic [2:0]        ex_wb_rd;
   logic [DATA_W-1:0] ex_wb_data;

   // register file and write port
   logic [DATA_W-1:0] rf [8];
   logic              wb_we;

   logic              stall;

   // IF: jump target uses the sign-extended 6-bit offset, wrapping modulo the PC width
   assign if_op      = Imem_Data[7:6];
   assign jmp_offset = PC_W'($signed(Imem_Data[5:0]));
   assign pc_next    = (if_op == OP_JMP) ? (pc + jmp_offset) : (pc + PC_W'(1));
   assign Imem_Addr  = pc;

   // ID: MOV reads rs, shifts read-modify-write rd
   assign id_op  = if_id_instr[7:6];
   assign id_rd  = if_id_instr[5:3];
   assign id_rs  = if_id_instr[2:0];
   assign id_src = (id_op == OP_MOV) ? id_rs : id_rd;

   // a register written this cycle is seen by the ID read in the same cycle
   assign wb_we   = ex_wb_valid && Run;
   assign id_opnd = (wb_we && (ex_wb_rd == id_src)) ? ex_wb_data : rf[id_src];

`ifdef PIPE_FWD_EN
   // the producer one ahead is caught in EX, so ID never waits
   assign stall   = 1'b0;
   assign ex_opnd = (ex_wb_valid && (ex_wb_rd == id_ex_src)) ? ex_wb_data : id_ex_opnd;
`else
   // a producer one ahead has not reached WB yet; hold ID one cycle so write-through covers it
   assign stall   = if_id_valid && id_ex_valid && (id_ex_rd == id_src);
   assign ex_opnd = id_ex_opnd;
`endif

   // EX: shift amounts at or beyond the datapath width clear the result
   always_comb begin
      ex_result = ex_opnd;
      case (id_ex_op)
         OP_SLL:  ex_result = (int'(id_ex_imm) >= DATA_W) ? '0 : (ex_opnd << id_ex_imm);
         OP_SRL:  ex_result = (int'(id_ex_imm) >= DATA_W) ? '0 : (ex_opnd >> id_ex_imm);
         default: ex_result = ex_opnd;
      endcase
   end

   // WB outputs are forced quiet while reset is asserted
   assign Wb_Valid = wb_we && !Reset;
   assign Wb_Reg   = Reset ? 3'd0 : ex_wb_rd;
   assign Wb_Data  = Reset ? '0 : ex_wb_data;

   // PC and IF/ID: a jump redirects fetch and leaves a bubble behind
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc          <= '0;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
      end else if (Run && !stall) begin
         pc          <= pc_next;
         if_id_valid <= (if_op != OP_JMP);
         if_id_instr <= Imem_Data;
      end
   end

   // ID/EX: capture operand and control, inserting a bubble on a stall
   always_ff @(posedge Clk) begin
      if (Reset) begin
         id_ex_valid <= 1'b0;
         id_ex_op    <= '0;
         id_ex_rd    <= '0;
         id_ex_imm   <= '0;
         id_ex_opnd  <= '0;
`ifdef PIPE_FWD_EN
         id_ex_src   <= '0;
`endif
      end else if (Run) begin
         id_ex_valid <= if_id_valid && !stall;
         id_ex_op    <= id_op;
         id_ex_rd    <= id_rd;
         id_ex_imm   <= id_rs;
         id_ex_opnd  <= id_opnd;
`ifdef PIPE_FWD_EN
         id_ex_src   <= id_src;
`endif
      end
   end

   // EX/WB: destination and data only move with a valid instruction so they stay zero until the first write
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ex_wb_valid <= 1'b0;
         ex_wb_rd    <= '0;
         ex_wb_data  <= '0;
      end else if (Run) begin
         ex_wb_valid <= id_ex_valid;
         if (id_ex_valid) begin
            ex_wb_rd   <= id_ex_rd;
            ex_wb_data <= ex_result;
         end
      end
   end

   // register file: reset loads each register with its own index
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++) begin
            rf[i] <= DATA_W'(i);
         end
      end else if (wb_we) begin
         rf[ex_wb_rd] <= ex_wb_data;
      end
   end

endmodule

// File: tb/tb_param_pipelined_core.sv
// tb/tb_param_pipelined_core.sv - self-checking bench for param_pipelined_core (8-bit and 4-bit datapaths)
module tb_param_pipelined_core;

   typedef struct {
      int cyc;
      int rg;
      int dat;
   } wr_t;

   typedef struct {
      logic [7:0] ins;
      int         rg;
      int         d8;
      int         d4;
   } vec_t;

   localparam int NV = 13;
`ifdef PIPE_FWD_EN
   localparam int DEP_CYC = 4;
`else
   localparam int DEP_CYC = 5;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Run;
   logic [7:0] Imem_Addr, Imem_Addr4;
   logic [7:0] Imem_Data, Imem_Data4;
   logic       Wb_Valid, Wb_Valid4;
   logic [2:0] Wb_Reg, Wb_Reg4;
   logic [7:0] Wb_Data;
   logic [3:0] Wb_Data4;

   logic [7:0] imem [256];
   logic [7:0] orig [256];
   wr_t        log_q[$];
   wr_t        log4_q[$];
   wr_t        exp_q[$];
   vec_t       vt [NV];
   int         checks;
   int         failures;
   int         cyc;

   assign Imem_Data  = imem[Imem_Addr];
   assign Imem_Data4 = imem[Imem_Addr4];

   always #5 Clk = ~Clk;

   param_pipelined_core #(.DATA_W(8), .PC_W(8)) u_dut (
      .Clk(Clk), .Reset(Reset), .Run(Run),
      .Imem_Addr(Imem_Addr), .Imem_Data(Imem_Data),
      .Wb_Valid(Wb_Valid), .Wb_Reg(Wb_Reg), .Wb_Data(Wb_Data)
   );

   param_pipelined_core #(.DATA_W(4), .PC_W(8)) u_dut4 (
      .Clk(Clk), .Reset(Reset), .Run(Run),
      .Imem_Addr(Imem_Addr4), .Imem_Data(Imem_Data4),
      .Wb_Valid(Wb_Valid4), .Wb_Reg(Wb_Reg4), .Wb_Data(Wb_Data4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // write logger; also a paused pipeline must never report a write
   always @(negedge Clk) begin
      wr_t w;
      if (Reset) begin
         cyc = 0;
      end else begin
         if (Wb_Valid) begin
            w.cyc = cyc; w.rg = int'(Wb_Reg); w.dat = int'(Wb_Data);
            log_q.push_back(w);
         end
         if (Wb_Valid4) begin
            w.cyc = cyc; w.rg = int'(Wb_Reg4); w.dat = int'(Wb_Data4);
            log4_q.push_back(w);
         end
         if (!Run) chk($sformatf("paused wb_valid c%0d", cyc), {31'd0, Wb_Valid | Wb_Valid4}, 0);
         cyc++;
      end
   end

   // instruction-level interpreter: architectural write sequence from reset state
   task automatic model_build(input int dw, input int n);
      int r [8];
      int pc, mask, steps, op, rd, rs, v, off;
      logic [7:0] ins;
      wr_t w;
      exp_q.delete();
      mask = (1 << dw) - 1;
      for (int i = 0; i < 8; i++) r[i] = i & mask;
      pc = 0;
      steps = 0;
      while (exp_q.size() < n && steps < 100000) begin
         ins = imem[pc];
         op = int'(ins[7:6]); rd = int'(ins[5:3]); rs = int'(ins[2:0]);
         steps++;
         if (op == 3) begin
            off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
            pc = (pc + off + 256) % 256;
         end else begin
            case (op)
               0:       v = r[rs];
               1:       v = (rs >= dw) ? 0 : ((r[rd] << rs) & mask);
               default: v = (rs >= dw) ? 0 : (r[rd] >> rs);
            endcase
            r[rd] = v;
            w.cyc = 0; w.rg = rd; w.dat = v;
            exp_q.push_back(w);
            pc = (pc + 1) % 256;
         end
      end
   endtask

   task automatic compare_logs(input string tag, input int min_writes);
      model_build(8, log_q.size());
      chk({tag, " w8 enough"}, {31'd0, log_q.size() >= min_writes}, 1);
      chk({tag, " w8 model size"}, exp_q.size(), log_q.size());
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s w8[%0d] reg", tag, i), log_q[i].rg, exp_q[i].rg);
         chk($sformatf("%s w8[%0d] data", tag, i), log_q[i].dat, exp_q[i].dat);
      end
      model_build(4, log4_q.size());
      chk({tag, " w4 enough"}, {31'd0, log4_q.size() >= min_writes}, 1);
      for (int i = 0; i < log4_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s w4[%0d] reg", tag, i), log4_q[i].rg, exp_q[i].rg);
         chk($sformatf("%s w4[%0d] data", tag, i), log4_q[i].dat, exp_q[i].dat);
      end
   endtask

   task automatic clear_imem();
      for (int a = 0; a < 256; a++) imem[a] = 8'h00;
   endtask

   // two reset edges, release just after a rising edge: caller is then in cycle 0
   task automatic reset_dut();
      @(posedge Clk); #1;
      Reset = 1'b1;
      Run   = 1'b1;
      @(negedge Clk);
      chk("in reset wb_valid", {31'd0, Wb_Valid | Wb_Valid4}, 0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      log_q.delete();
      log4_q.delete();
   endtask

   initial begin
      logic [7:0] held;
      int runs, off, tgt;
      checks   = 0;
      failures = 0;
      Reset    = 1'b1;
      Run      = 1'b0;
      clear_imem();

      vt[0]  = '{8'h2A, 5, 2,   2};
      vt[1]  = '{8'hB9, 7, 3,   3};
      vt[2]  = '{8'h4F, 1, 128, 0};
      vt[3]  = '{8'h5A, 3, 12,  12};
      vt[4]  = '{8'h0B, 1, 3,   3};
      vt[5]  = '{8'h87, 0, 0,   0};
      vt[6]  = '{8'h7F, 7, 128, 0};
      vt[7]  = '{8'hA4, 4, 0,   0};
      vt[8]  = '{8'h63, 4, 32,  0};
      vt[9]  = '{8'h91, 2, 1,   1};
      vt[10] = '{8'h35, 6, 5,   5};
      vt[11] = '{8'h6D, 5, 160, 0};
      vt[12] = '{8'hBA, 7, 1,   1};

      // single instruction at address 0: reset outputs, fetch order, exact three-cycle latency
      for (int v = 0; v < NV; v++) begin
         clear_imem();
         imem[0] = vt[v].ins;
         reset_dut();
         @(negedge Clk);
         chk($sformatf("vec%0d c0 wb_valid", v), {31'd0, Wb_Valid}, 0);
         chk($sformatf("vec%0d c0 wb_reg", v), {29'd0, Wb_Reg}, 0);
         chk($sformatf("vec%0d c0 wb_data", v), {24'd0, Wb_Data}, 0);
         chk($sformatf("vec%0d c0 addr", v), {24'd0, Imem_Addr}, 0);
         @(negedge Clk);
         chk($sformatf("vec%0d c1 addr", v), {24'd0, Imem_Addr}, 1);
         @(negedge Clk);
         chk($sformatf("vec%0d c2 wb_valid", v), {31'd0, Wb_Valid}, 0);
         @(negedge Clk);
         chk($sformatf("vec%0d c3 wb_valid", v), {31'd0, Wb_Valid}, 1);
         chk($sformatf("vec%0d c3 wb_reg", v), {29'd0, Wb_Reg}, vt[v].rg);
         chk($sformatf("vec%0d c3 wb_data", v), {24'd0, Wb_Data}, vt[v].d8);
         chk($sformatf("vec%0d c3 wb_valid4", v), {31'd0, Wb_Valid4}, 1);
         chk($sformatf("vec%0d c3 wb_data4", v), {28'd0, Wb_Data4}, vt[v].d4);
      end

      // back-to-back dependence: SLL R3,2 then MOV R1<-R3
      clear_imem();
      imem[0] = 8'h5A;
      imem[1] = 8'h0B;
      reset_dut();
      repeat (8) @(negedge Clk);
      chk("dep count", {31'd0, log_q.size() >= 2}, 1);
      if (log_q.size() >= 2) begin
         chk("dep w0 cycle", log_q[0].cyc, 3);
         chk("dep w0 reg", log_q[0].rg, 3);
         chk("dep w0 data", log_q[0].dat, 12);
         chk("dep w1 cycle", log_q[1].cyc, DEP_CYC);
         chk("dep w1 reg", log_q[1].rg, 1);
         chk("dep w1 data", log_q[1].dat, 12);
      end
      if (log4_q.size() >= 2) chk("dep4 w1 data", log4_q[1].dat, 12);
      else chk("dep4 count", log4_q.size(), 2);

      // backward jump at address 4
      clear_imem();
      imem[0] = 8'h2A; imem[1] = 8'h09; imem[2] = 8'h12; imem[3] = 8'h1B; imem[4] = 8'hFE;
      reset_dut();
      repeat (5) @(negedge Clk);
      chk("jmp fetch addr", {24'd0, Imem_Addr}, 4);
      @(negedge Clk);
      chk("jmp target addr", {24'd0, Imem_Addr}, 2);
      chk("jmp target addr4", {24'd0, Imem_Addr4}, 2);
      @(negedge Clk);
      chk("jmp after target addr", {24'd0, Imem_Addr}, 3);
      @(negedge Clk);
      chk("jmp slot wb_valid", {31'd0, Wb_Valid}, 0);
      repeat (12) @(negedge Clk);
      compare_logs("jmp loop", 6);

      // JMP -1 at address 0 wraps to the top of the address space
      clear_imem();
      imem[0] = 8'hFF;
      reset_dut();
      @(negedge Clk);
      chk("jmp wrap c0 addr", {24'd0, Imem_Addr}, 0);
      @(negedge Clk);
      chk("jmp wrap addr", {24'd0, Imem_Addr}, 255);
      chk("jmp wrap addr4", {24'd0, Imem_Addr4}, 255);

      // three-cycle pause inside a dependent loop
      clear_imem();
      imem[0] = 8'h5A; imem[1] = 8'h0B; imem[2] = 8'h49;
      imem[3] = 8'h8B; imem[4] = 8'h13; imem[5] = 8'hFB;
      reset_dut();
      repeat (6) @(negedge Clk);
      @(posedge Clk); #1;
      Run = 1'b0;
      @(negedge Clk);
      held = Imem_Addr;
      repeat (2) begin
         @(negedge Clk);
         chk("pause addr held", {24'd0, Imem_Addr}, {24'd0, held});
      end
      @(posedge Clk); #1;
      Run = 1'b1;
      repeat (30) @(negedge Clk);
      compare_logs("pause", 8);

      // reset with three instructions in flight
      clear_imem();
      for (int i = 0; i < 8; i++) imem[i] = 8'(8'h41 | (i << 3));
      reset_dut();
      repeat (5) @(negedge Clk);
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(negedge Clk);
      chk("mid reset wb_valid", {31'd0, Wb_Valid | Wb_Valid4}, 0);
      clear_imem();
      for (int i = 0; i < 8; i++) imem[i] = 8'((i << 3) | i);
      @(posedge Clk); #1;
      Reset = 1'b0;
      log_q.delete();
      log4_q.delete();
      @(negedge Clk);
      chk("mid reset addr", {24'd0, Imem_Addr}, 0);
      chk("mid reset c0 wb_valid", {31'd0, Wb_Valid}, 0);
      repeat (14) @(negedge Clk);
      if (log_q.size() > 0) chk("mid reset first write cycle", log_q[0].cyc, 3);
      compare_logs("mid reset", 8);

      // random programs with random pauses against the interpreter
      for (int t = 0; t < 4; t++) begin
         for (int a = 0; a < 256; a++) begin
            orig[a] = 8'($urandom);
            imem[a] = orig[a];
         end
         for (int a = 0; a < 256; a++) begin
            if (orig[a][7:6] == 2'b11) begin
               off = orig[a][5] ? int'(orig[a][5:0]) - 64 : int'(orig[a][5:0]);
               tgt = (a + off + 256) % 256;
               if (orig[tgt][7:6] == 2'b11) imem[a] = {2'b00, orig[a][5:0]};
            end
         end
         reset_dut();
         runs = 0;
         for (int c = 0; c < 150; c++) begin
            Run = ($urandom_range(0, 3) != 0);
            if (Run) runs++;
            @(posedge Clk); #1;
         end
         Run = 1'b1;
         compare_logs($sformatf("rand%0d", t), runs / 4 - 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
